// File: rtl/seq_alu.sv
// Multi-cycle signed ALU: single-cycle logic/arith ops, radix-4 Booth multiply and
// non-restoring divide with a double-width HI/LO result. Optional status flags under SEQ_ALU_FLAGS_EN.
module seq_alu #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
`ifdef SEQ_ALU_FLAGS_EN
    ,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
`endif
);

    // Handshake: a request is taken on any rising edge with start=1 and ready=1; start
    // while ready=0 is dropped. done pulses for one cycle and the results stay put until
    // the next done, so the control unit can read them at its leisure.

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] MUL_STEPS = CW'(WIDTH / 2);
    localparam logic [CW-1:0] DIV_STEPS = CW'(WIDTH);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_NEG  = 4'd2;
    localparam logic [3:0] OP_SHR  = 4'd3;
    localparam logic [3:0] OP_SHRA = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_ROR  = 4'd6;
    localparam logic [3:0] OP_ROL  = 4'd7;
    localparam logic [3:0] OP_ADD  = 4'd8;
    localparam logic [3:0] OP_SUB  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIV  = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t state;

    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               dbz_q;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               booth_prev;
    logic [2*WIDTH-1:0] booth_term;

    logic [WIDTH+1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   dvs;
    logic               q_neg;
    logic               r_neg;
    logic [CW-1:0]      count;

    logic               in_dbz;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [SHW-1:0]     shamt;
    logic [SHW:0]       inv_sh;
    logic [WIDTH-1:0]   exec_lo;

    logic [WIDTH+1:0]   rem_sh;
    logic [WIDTH+1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic [WIDTH-1:0]   rem_mag;
    logic [WIDTH-1:0]   div_lo;
    logic [WIDTH-1:0]   div_hi;

    logic               finishing;
    logic [WIDTH-1:0]   fin_lo;
    logic [WIDTH-1:0]   fin_hi;
    logic               fin_dbz;

    // Accept-time decode: divide-by-zero short-circuits to EXEC, otherwise magnitudes feed the divider.
    assign in_dbz = (op == OP_DIV) && (B == '0);
    assign a_mag  = A[WIDTH-1] ? ('0 - A) : A;
    assign b_mag  = B[WIDTH-1] ? ('0 - B) : B;

    assign shamt  = b_q[SHW-1:0];
    assign inv_sh = (SHW + 1)'(WIDTH) - {1'b0, shamt};

    always_comb begin
        exec_lo = '0;
        case (op_q)
            OP_AND:  exec_lo = a_q & b_q;
            OP_OR:   exec_lo = a_q | b_q;
            OP_NEG:  exec_lo = '0 - a_q;
            OP_SHR:  exec_lo = a_q >> shamt;
            OP_SHRA: exec_lo = WIDTH'($signed(a_q) >>> shamt);
            OP_SHL:  exec_lo = a_q << shamt;
            OP_ROR:  exec_lo = (a_q >> shamt) | (a_q << inv_sh);
            OP_ROL:  exec_lo = (a_q << shamt) | (a_q >> inv_sh);
            OP_ADD:  exec_lo = a_q + b_q;
            OP_SUB:  exec_lo = a_q - b_q;
            default: exec_lo = '0;
        endcase
    end

    // Bit-pair recoding of {b[i+1], b[i], b[i-1]}; mcand is pre-shifted to the digit weight.
    always_comb begin
        booth_term = '0;
        case ({mplier[1:0], booth_prev})
            3'b001, 3'b010: booth_term = mcand;
            3'b011:         booth_term = mcand << 1;
            3'b100:         booth_term = '0 - (mcand << 1);
            3'b101, 3'b110: booth_term = '0 - mcand;
            default:        booth_term = '0;
        endcase
    end

    assign rem_sh   = {rem[WIDTH:0], quo[WIDTH-1]};
    assign rem_step = rem[WIDTH+1] ? (rem_sh + {2'b00, dvs}) : (rem_sh - {2'b00, dvs});
    assign quo_step = {quo[WIDTH-2:0], ~rem_step[WIDTH+1]};
    assign rem_mag  = rem[WIDTH-1:0] + (rem[WIDTH+1] ? dvs : '0);
    assign div_lo   = q_neg ? ('0 - quo) : quo;
    assign div_hi   = r_neg ? ('0 - rem_mag) : rem_mag;

    assign finishing = (state == S_EXEC) || (state == S_FIX) ||
                       ((state == S_MUL) && (count == '0));

    always_comb begin
        fin_lo  = exec_lo;
        fin_hi  = '0;
        fin_dbz = 1'b0;
        case (state)
            S_EXEC: begin
                if (dbz_q) begin
                    fin_lo  = '1;
                    fin_hi  = a_q;
                    fin_dbz = 1'b1;
                end
            end
            S_MUL: begin
                fin_lo = acc[WIDTH-1:0];
                fin_hi = acc[2*WIDTH-1:WIDTH];
            end
            S_FIX: begin
                fin_lo = div_lo;
                fin_hi = div_hi;
            end
            default: begin
                fin_lo = exec_lo;
            end
        endcase
    end

`ifdef SEQ_ALU_FLAGS_EN
    logic fin_z;
    logic fin_n;
    logic fin_v;

    always_comb begin
        fin_v = 1'b0;
        if ((state == S_EXEC) && !dbz_q) begin
            case (op_q)
                OP_ADD:  fin_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (exec_lo[WIDTH-1] != a_q[WIDTH-1]);
                OP_SUB:  fin_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (exec_lo[WIDTH-1] != a_q[WIDTH-1]);
                OP_NEG:  fin_v = (a_q == {1'b1, {(WIDTH-1){1'b0}}});
                default: fin_v = 1'b0;
            endcase
        end
    end

    assign fin_z = (fin_lo == '0) && ((state != S_MUL) || (fin_hi == '0));
    assign fin_n = (state == S_MUL) ? fin_hi[WIDTH-1] : fin_lo[WIDTH-1];
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= S_IDLE;
            ready       <= 1'b1;
            done        <= 1'b0;
            result_lo   <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            dbz_q       <= 1'b0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            booth_prev  <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            count       <= '0;
`ifdef SEQ_ALU_FLAGS_EN
            flag_z      <= 1'b0;
            flag_n      <= 1'b0;
            flag_v      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_q  <= op;
                        a_q   <= A;
                        b_q   <= B;
                        dbz_q <= in_dbz;
                        ready <= 1'b0;
                        if (op == OP_MUL) begin
                            acc        <= '0;
                            mcand      <= {{WIDTH{A[WIDTH-1]}}, A};
                            mplier     <= B;
                            booth_prev <= 1'b0;
                            count      <= MUL_STEPS;
                            state      <= S_MUL;
                        end else if ((op == OP_DIV) && !in_dbz) begin
                            rem   <= '0;
                            quo   <= a_mag;
                            dvs   <= b_mag;
                            q_neg <= A[WIDTH-1] ^ B[WIDTH-1];
                            r_neg <= A[WIDTH-1];
                            count <= DIV_STEPS;
                            state <= S_DIV;
                        end else begin
                            state <= S_EXEC;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    if (count != '0) begin
                        acc        <= acc + booth_term;
                        mcand      <= mcand << 2;
                        mplier     <= mplier >> 2;
                        booth_prev <= mplier[1];
                        count      <= count - CW'(1);
                    end
                end
                S_DIV: begin
                    if (count == '0) begin
                        state <= S_FIX;
                    end else begin
                        rem   <= rem_step;
                        quo   <= quo_step;
                        count <= count - CW'(1);
                    end
                end
                default: begin
                    state <= state;
                end
            endcase

            if (finishing) begin
                state       <= S_DONE;
                ready       <= 1'b1;
                done        <= 1'b1;
                result_lo   <= fin_lo;
                result_hi   <= fin_hi;
                div_by_zero <= fin_dbz;
`ifdef SEQ_ALU_FLAGS_EN
                flag_z      <= fin_z;
                flag_n      <= fin_n;
                flag_v      <= fin_v;
`endif
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at WIDTH=32: directed corner cases plus random ops, checked by a
// scoreboard against an arithmetic reference model (results, latency, ready, result hold).
module tb_seq_alu;

    localparam int W = 32;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_NEG  = 4'd2;
    localparam logic [3:0] OP_SHR  = 4'd3;
    localparam logic [3:0] OP_SHRA = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_ROR  = 4'd6;
    localparam logic [3:0] OP_ROL  = 4'd7;
    localparam logic [3:0] OP_ADD  = 4'd8;
    localparam logic [3:0] OP_SUB  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIV  = 4'd11;

    logic         clock;
    logic         clear;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         ready;
    logic         done;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;
    logic         div_by_zero;
`ifdef SEQ_ALU_FLAGS_EN
    logic         flag_z;
    logic         flag_n;
    logic         flag_v;
`endif

    seq_alu #(.WIDTH(W)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .ready       (ready),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero)
`ifdef SEQ_ALU_FLAGS_EN
        ,
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .flag_v      (flag_v)
`endif
    );

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dbz;
        int           acc_edge;
        int           done_edge;
    } exp_t;

    exp_t exp_q[$];
    exp_t hold;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   skip_ready = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input int acc_edge);
        exp_t         e;
        longint       sa;
        longint       sb;
        logic [63:0]  pv;
        logic [W-1:0] t;
        int           sh;
        int           lat;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        sh    = int'(b % W);
        e.lo  = '0;
        e.hi  = '0;
        e.dbz = 1'b0;
        lat   = 1;
        t     = a;
        case (o)
            OP_AND:  e.lo = a & b;
            OP_OR:   e.lo = a | b;
            OP_NEG:  begin pv = 64'(0 - sa); e.lo = pv[W-1:0]; end
            OP_SHR:  e.lo = a >> sh;
            OP_SHRA: begin repeat (sh) t = {t[W-1], t[W-1:1]}; e.lo = t; end
            OP_SHL:  e.lo = a << sh;
            OP_ROR:  begin repeat (sh) t = {t[0], t[W-1:1]}; e.lo = t; end
            OP_ROL:  begin repeat (sh) t = {t[W-2:0], t[W-1]}; e.lo = t; end
            OP_ADD:  begin pv = 64'(sa + sb); e.lo = pv[W-1:0]; end
            OP_SUB:  begin pv = 64'(sa - sb); e.lo = pv[W-1:0]; end
            OP_MUL: begin
                pv   = 64'(sa * sb);
                e.lo = pv[W-1:0];
                e.hi = pv[63:W];
                lat  = W / 2 + 1;
            end
            OP_DIV: begin
                if (b == '0) begin
                    e.lo  = '1;
                    e.hi  = a;
                    e.dbz = 1'b1;
                end else begin
                    pv   = 64'(sa / sb);
                    e.lo = pv[W-1:0];
                    pv   = 64'(sa % sb);
                    e.hi = pv[W-1:0];
                    lat  = W + 2;
                end
            end
            default: e.lo = '0;
        endcase
        e.acc_edge  = acc_edge;
        e.done_edge = acc_edge + lat;
        return e;
    endfunction

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (edge %0d)", name, act, want, cyc);
        end
    endfunction

    // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit track);
        int guard;
        guard = 0;
        while (ready !== 1'b1 && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        check("ready_before_issue", 64'(ready), 64'(1));
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        if (track) exp_q.push_back(model(o, a, b, cyc + 1));
        @(negedge clock);
    endtask

    task automatic drain();
        int guard;
        start = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        check("drain", 64'(exp_q.size()), 64'(0));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return W'($urandom_range(0, 40));
            default: return W'($urandom);
        endcase
    endfunction

    // ---------------- scoreboard monitor ----------------
    always begin : monitor
        exp_t e;
        bit   busy;
        @(posedge clock);
        #1;
        if (clear) begin
            busy = (exp_q.size() > 0) && (cyc >= exp_q[0].acc_edge) && (cyc < exp_q[0].done_edge);
            if (!skip_ready) check("ready", 64'(ready), 64'(!busy));
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("result_lo", 64'(result_lo), 64'(e.lo));
                    check("result_hi", 64'(result_hi), 64'(e.hi));
                    check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                    check("latency_edge", 64'(cyc), 64'(e.done_edge));
                    hold = e;
                end
            end else begin
                check("hold", {result_hi, result_lo}, {hold.hi, hold.lo});
                check("hold_dbz", 64'(div_by_zero), 64'(hold.dbz));
                if (exp_q.size() > 0 && cyc > exp_q[0].done_edge) begin
                    check("missing_done_edge", 64'(cyc), 64'(exp_q[0].done_edge));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int e0;
        logic [3:0]   o;
        logic [W-1:0] a;
        logic [W-1:0] b;
        clear    = 1'b0;
        start    = 1'b0;
        op       = '0;
        A        = '0;
        B        = '0;
        hold.lo  = '0;
        hold.hi  = '0;
        hold.dbz = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_ready", 64'(ready), 64'(1));
        check("reset_done", 64'(done), 64'(0));
        check("reset_lo", 64'(result_lo), 64'(0));
        check("reset_hi", 64'(result_hi), 64'(0));
        check("reset_dbz", 64'(div_by_zero), 64'(0));
        clear = 1'b1;
        @(negedge clock);

        // reset in the middle of a divide: no done, everything back to zero
        skip_ready = 1'b1;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        e0    = cyc;
        start = 1'b0;
        while (cyc < e0 + 9) @(negedge clock);
        check("mid_div_busy", 64'(ready), 64'(0));
        clear = 1'b0;
        #1;
        check("abort_ready", 64'(ready), 64'(1));
        check("abort_done", 64'(done), 64'(0));
        check("abort_lo", 64'(result_lo), 64'(0));
        check("abort_hi", 64'(result_hi), 64'(0));
        @(negedge clock);
        clear      = 1'b1;
        skip_ready = 1'b0;
        repeat (40) @(negedge clock);
        issue(OP_ADD, 32'd3, 32'd4, 1'b1);
        drain();

        // multiply with start held high (and ignored) during the iterations
        issue(OP_MUL, 32'hFFFF_FFFF, 32'h0000_0005, 1'b1);
        repeat (10) begin
            op = OP_AND;
            A  = W'($urandom);
            B  = W'($urandom);
            @(negedge clock);
        end
        drain();

        issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
        drain();
        issue(OP_DIV, 32'h0000_000A, 32'h0000_0000, 1'b1);
        drain();

        // shifts with amount field 1 and upper B bits set, issued back to back
        issue(OP_ROR, 32'h8000_0001, 32'h0000_0021, 1'b1);
        issue(OP_SHRA, 32'h8000_0000, 32'h0000_0021, 1'b1);
        issue(OP_SHR, 32'h8000_0000, 32'h0000_0021, 1'b1);
        issue(4'd13, 32'h8000_0000, 32'h0000_0021, 1'b1);
        drain();

        issue(OP_SUB, 32'd5, 32'd9, 1'b1);
        issue(OP_NEG, 32'd1, 32'd0, 1'b1);
        drain();

        // most-negative corners
        issue(OP_MUL, 32'h8000_0000, 32'h8000_0000, 1'b1);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(OP_DIV, 32'h8000_0000, 32'h0000_0007, 1'b1);
        issue(OP_ROL, 32'h8000_0001, 32'h0000_0000, 1'b1);
        issue(OP_ROL, 32'h1234_5678, 32'h0000_001F, 1'b1);
        drain();

        for (int i = 0; i < 80; i++) begin
            o = 4'($urandom_range(0, 15));
            a = pick();
            b = pick();
            if (o == OP_DIV && $urandom_range(0, 5) == 0) b = '0;
            issue(o, a, b, 1'b1);
            if ($urandom_range(0, 2) != 0) begin
                start = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clock);
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
